pi_state_bank: RTL and testbench

- Multi-channel state store for the servo PI controller datapath.
- Per channel it holds a DEPTH-tap history of past outputs y[k-1..k-DEPTH] and a saturated integrator state i[k-1].
- It also tracks history fill and exposes a registered read port, so one time-multiplexed PI datapath can serve NCH servo axes.
- Supports integrator preload for bumpless transfer and per-channel clear.

---
 rtl/pi_pkg.sv | 29 ++
 rtl/pi_chan_state.sv | 56 +++++
 rtl/pi_state_bank.sv | 106 ++++++++++
 tb/tb_pi_state_bank.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// Shared definitions for the servo PI datapath: default widths, integrator
// clamp limits, per-channel command encoding and the saturating clamp helper.
package pi_pkg;

  localparam int YW_DEF    = 9;
  localparam int IW_DEF    = 17;
  localparam int I_MAX_DEF = 65535;
  localparam int I_MIN_DEF = -65536;

  // Working width of the clamp helper; any IW+1 up to PW fits after sign extension.
  localparam int PW = 32;

  // One-hot per-channel command, already priority-resolved by the caller.
  typedef struct packed {
    logic clr;
    logic load;
    logic save;
  } cmd_t;

  // Returns {sat, clamped}; sat is set when value had to be limited.
  function automatic logic [PW:0] sat_clamp(input logic signed [PW-1:0] value,
                                            input logic signed [PW-1:0] max,
                                            input logic signed [PW-1:0] min);
    if (value > max)      return {1'b1, max};
    else if (value < min) return {1'b1, min};
    else                  return {1'b0, value};
  endfunction

endpackage

// File: rtl/pi_chan_state.sv
// State of one servo channel: output history taps, saturated integrator,
// clamp flag and history fill count.
module pi_chan_state
  import pi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int YW    = YW_DEF,
  parameter int IW    = IW_DEF,
  parameter int I_MAX = I_MAX_DEF,
  parameter int I_MIN = I_MIN_DEF,
  localparam int FW   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  cmd_t                   cmd,
  input  logic signed [YW-1:0]   yk,
  input  logic signed [IW:0]     ik,
  input  logic signed [IW-1:0]   ld_val,
  output logic [DEPTH*YW-1:0]    taps,
  output logic signed [IW-1:0]   istate,
  output logic                   sat,
  output logic [FW-1:0]          fill
);

  logic signed [YW-1:0] tap [DEPTH];
  logic signed [PW-1:0] ik_ext;
  logic [PW:0]          clamp_r;

  assign ik_ext  = {{(PW-IW-1){ik[IW]}}, ik};
  assign clamp_r = sat_clamp(ik_ext, I_MAX, I_MIN);

  always_ff @(posedge clk) begin
    if (rst || cmd.clr) begin
      for (int j = 0; j < DEPTH; j++) tap[j] <= '0;
      istate <= '0;
      sat    <= 1'b0;
      fill   <= '0;
    end else if (cmd.load) begin
      istate <= ld_val;
      sat    <= 1'b0;
    end else if (cmd.save) begin
      tap[0] <= yk;
      for (int j = 1; j < DEPTH; j++) tap[j] <= tap[j-1];
      istate <= clamp_r[IW-1:0];
      sat    <= clamp_r[PW];
      // Fill saturates at DEPTH so it never wraps on long runs.
      if (fill != FW'(DEPTH)) fill <= fill + FW'(1);
    end
  end

  always_comb begin
    taps = '0;
    for (int j = 0; j < DEPTH; j++) taps[j*YW +: YW] = tap[j];
  end

endmodule

// File: rtl/pi_state_bank.sv
// Multi-channel PI state store: decodes save/load/clr onto one channel and
// presents the selected channel's state through a registered read port.
module pi_state_bank
  import pi_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 2,
  parameter int YW    = YW_DEF,
  parameter int IW    = IW_DEF,
  parameter int I_MAX = I_MAX_DEF,
  parameter int I_MIN = I_MIN_DEF,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int FW   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save,
  input  logic                  load,
  input  logic                  clr,
  input  logic [CW-1:0]         ch,
  input  logic signed [YW-1:0]  yk,
  input  logic signed [IW:0]    ik,
  input  logic signed [IW-1:0]  ld_val,
  input  logic [CW-1:0]         rd_ch,
  output logic [DEPTH*YW-1:0]   y_hist,
  output logic signed [IW-1:0]  ik1,
  output logic                  sat,
  output logic [FW-1:0]         fill,
  output logic                  hist_full
);

  logic [DEPTH*YW-1:0]  taps_a [NCH];
  logic signed [IW-1:0] istate_a [NCH];
  logic                 sat_a [NCH];
  logic [FW-1:0]        fill_a [NCH];

  logic ch_ok;
  assign ch_ok = (int'(ch) < NCH);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic sel;
    cmd_t cmd;
    assign sel      = ch_ok && (ch == CW'(c));
    assign cmd.clr  = sel && clr;
    assign cmd.load = sel && load && !clr;
    assign cmd.save = sel && save && !clr && !load;

    pi_chan_state #(
      .DEPTH (DEPTH),
      .YW    (YW),
      .IW    (IW),
      .I_MAX (I_MAX),
      .I_MIN (I_MIN)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .cmd    (cmd),
      .yk     (yk),
      .ik     (ik),
      .ld_val (ld_val),
      .taps   (taps_a[c]),
      .istate (istate_a[c]),
      .sat    (sat_a[c]),
      .fill   (fill_a[c])
    );
  end

  // Read mux: out-of-range rd_ch falls through to the zero defaults.
  logic [DEPTH*YW-1:0]  y_mux;
  logic signed [IW-1:0] i_mux;
  logic                 s_mux;
  logic [FW-1:0]        f_mux;

  always_comb begin
    y_mux = '0;
    i_mux = '0;
    s_mux = 1'b0;
    f_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(rd_ch) == c) begin
        y_mux = taps_a[c];
        i_mux = istate_a[c];
        s_mux = sat_a[c];
        f_mux = fill_a[c];
      end
    end
  end

  // Output register stage: samples pre-write state, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_hist    <= '0;
      ik1       <= '0;
      sat       <= 1'b0;
      fill      <= '0;
      hist_full <= 1'b0;
    end else begin
      y_hist    <= y_mux;
      ik1       <= i_mux;
      sat       <= s_mux;
      fill      <= f_mux;
      hist_full <= (f_mux == FW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_pi_state_bank.sv
// Directed bench for pi_state_bank: a 4-channel instance for the main checks
// and a 5-channel instance where out-of-range channel indices are representable.
module tb_pi_state_bank;

  localparam int YW = 9;
  localparam int IW = 17;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst, save, load, clr;
  logic [1:0] ch, rd_ch;
  logic [2:0] ch5, rd_ch5;
  logic signed [YW-1:0] yk;
  logic signed [IW:0]   ik;
  logic signed [IW-1:0] ld_val;

  logic [2*YW-1:0]      y_hist, y_hist5;
  logic signed [IW-1:0] ik1, ik15;
  logic                 sat, sat5, hist_full, hist_full5;
  logic [FW-1:0]        fill, fill5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pi_state_bank dut (
    .clk(clk), .rst(rst), .save(save), .load(load), .clr(clr), .ch(ch),
    .yk(yk), .ik(ik), .ld_val(ld_val), .rd_ch(rd_ch),
    .y_hist(y_hist), .ik1(ik1), .sat(sat), .fill(fill), .hist_full(hist_full)
  );

  pi_state_bank #(.NCH(5)) dut5 (
    .clk(clk), .rst(rst), .save(save), .load(load), .clr(clr), .ch(ch5),
    .yk(yk), .ik(ik), .ld_val(ld_val), .rd_ch(rd_ch5),
    .y_hist(y_hist5), .ik1(ik15), .sat(sat5), .fill(fill5), .hist_full(hist_full5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2*YW-1:0] yh,
                           input logic signed [IW-1:0] iv, input logic s,
                           input logic [FW-1:0] f, input logic hf,
                           input longint e0, input longint e1, input longint ei,
                           input int es, input int ef);
    chk({tag, ".y1"},   longint'($signed(yh[YW-1:0])), e0);
    chk({tag, ".y2"},   longint'($signed(yh[2*YW-1:YW])), e1);
    chk({tag, ".ik1"},  longint'(iv), ei);
    chk({tag, ".sat"},  longint'(s), longint'(es));
    chk({tag, ".fill"}, longint'(f), longint'(ef));
    chk({tag, ".full"}, longint'(hf), (ef == 2) ? 64'sd1 : 64'sd0);
  endtask

  // Select a channel on the 4-channel instance, wait one edge, check it.
  task automatic rd(input string tag, input logic [1:0] c, input longint e0,
                    input longint e1, input longint ei, input int es, input int ef);
    rd_ch = c;
    tick();
    chk_state(tag, y_hist, ik1, sat, fill, hist_full, e0, e1, ei, es, ef);
  endtask

  task automatic do_save(input logic [1:0] c, input int y, input int i);
    ch = c; yk = YW'(y); ik = (IW+1)'(i); save = 1'b1;
    tick();
    save = 1'b0;
  endtask

  initial begin
    rst = 1'b1; save = 1'b0; load = 1'b0; clr = 1'b0;
    ch = '0; rd_ch = '0; ch5 = 3'd7; rd_ch5 = '0;
    yk = '0; ik = '0; ld_val = '0;
    tick();
    tick();
    // Commands asserted together with reset must be ignored.
    ch = 2'd1; yk = 9'sd5; ik = 18'sd100; save = 1'b1; load = 1'b1;
    ld_val = 17'sd33; rd_ch = 2'd1;
    tick();
    save = 1'b0; load = 1'b0; rst = 1'b0;
    chk_state("reset_out", y_hist, ik1, sat, fill, hist_full, 0, 0, 0, 0, 0);
    rd("rst_ch0", 2'd0, 0, 0, 0, 0, 0);
    rd("rst_ch1", 2'd1, 0, 0, 0, 0, 0);
    rd("rst_ch2", 2'd2, 0, 0, 0, 0, 0);
    rd("rst_ch3", 2'd3, 0, 0, 0, 0, 0);
    rd_ch5 = 3'd1;
    tick();
    chk_state("rst5_ch1", y_hist5, ik15, sat5, fill5, hist_full5, 0, 0, 0, 0, 0);

    // History shift and fill saturation on ch1.
    do_save(2'd1, 5, 0);
    rd("ch1_s1", 2'd1, 5, 0, 0, 0, 1);
    do_save(2'd1, -3, 0);
    rd("ch1_s2", 2'd1, -3, 5, 0, 0, 2);
    do_save(2'd1, 7, 0);
    rd("ch1_s3", 2'd1, 7, -3, 0, 0, 2);

    // Integrator clamp and its boundaries on ch2.
    do_save(2'd2, 1, 70000);
    rd("ch2_hi", 2'd2, 1, 0, 65535, 1, 1);
    do_save(2'd2, 1, -70000);
    rd("ch2_lo", 2'd2, 1, 1, -65536, 1, 2);
    do_save(2'd2, 1, 65535);
    rd("ch2_eqmax", 2'd2, 1, 1, 65535, 0, 2);
    do_save(2'd2, 1, 65536);
    rd("ch2_max1", 2'd2, 1, 1, 65535, 1, 2);
    do_save(2'd2, 1, -65536);
    rd("ch2_eqmin", 2'd2, 1, 1, -65536, 0, 2);
    do_save(2'd2, 1, -65537);
    rd("ch2_min1", 2'd2, 1, 1, -65536, 1, 2);
    do_save(2'd2, 1, 1234);
    rd("ch2_mid", 2'd2, 1, 1, 1234, 0, 2);

    // Load beats save and clears sat; clr beats load.
    do_save(2'd0, 4, 70000);
    rd("ch0_pre", 2'd0, 4, 0, 65535, 1, 1);
    ch = 2'd0; yk = 9'sd9; ik = 18'sd77; ld_val = -17'sd500;
    load = 1'b1; save = 1'b1;
    tick();
    load = 1'b0; save = 1'b0;
    rd("ch0_load", 2'd0, 4, 0, -500, 0, 1);
    ld_val = 17'sd321; clr = 1'b1; load = 1'b1;
    tick();
    clr = 1'b0; load = 1'b0;
    rd("ch0_clr", 2'd0, 0, 0, 0, 0, 0);

    // Read-before-write on ch3.
    do_save(2'd3, 8, 0);
    rd("ch3_pre", 2'd3, 8, 0, 0, 0, 1);
    ch = 2'd3; yk = 9'sd42; ik = 18'sd0; save = 1'b1;
    tick();
    save = 1'b0;
    chk_state("ch3_rbw0", y_hist, ik1, sat, fill, hist_full, 8, 0, 0, 0, 1);
    tick();
    chk_state("ch3_rbw1", y_hist, ik1, sat, fill, hist_full, 42, 8, 0, 0, 2);
    rd("ind_ch0", 2'd0, 0, 0, 0, 0, 0);
    rd("ind_ch1", 2'd1, 7, -3, 0, 0, 2);
    rd("ind_ch2", 2'd2, 1, 1, 1234, 0, 2);

    // Out-of-range indices on the 5-channel instance (ch5 was 7 throughout).
    rd_ch5 = 3'd0;
    tick();
    chk_state("oor5_ch0", y_hist5, ik15, sat5, fill5, hist_full5, 0, 0, 0, 0, 0);
    ch5 = 3'd4; yk = 9'sd11; ik = 18'sd0; save = 1'b1;
    tick();
    ch5 = 3'd5; yk = 9'sd22;
    tick();
    ch5 = 3'd7; save = 1'b0;
    rd_ch5 = 3'd4;
    tick();
    chk_state("oor5_ch4", y_hist5, ik15, sat5, fill5, hist_full5, 11, 0, 0, 0, 1);
    rd_ch5 = 3'd1;
    tick();
    chk_state("oor5_ch1", y_hist5, ik15, sat5, fill5, hist_full5, 0, 0, 0, 0, 0);
    rd_ch5 = 3'd4;
    tick();
    rd_ch5 = 3'd5;
    tick();
    chk_state("oor5_rd5", y_hist5, ik15, sat5, fill5, hist_full5, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
